alu_hs: RTL

- Parametrised successor to the single-cycle ALU.
- WIDTH-bit integer ALU with valid/ready handshakes on input and output, and a one-entry registered output.
- Adds arithmetic shift, signed and unsigned set-less-than, an iterative multiply (low WIDTH bits), carry and overflow flags, an illegal-op error flag, and a synchronous flush.
- Sits between the decode/issue stage and writeback; downstream may stall the result.

---
 rtl/alu_hs.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/alu_hs.sv
// alu_hs: WIDTH-bit integer ALU with valid/ready handshakes on both sides,
// a shift-add multiplier and a one-entry registered result with flags.
module alu_hs #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] operand0,
    input  logic [WIDTH-1:0] operand1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             err
);

    localparam int unsigned CW = SHW + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SRL  = 4'd3;
    localparam logic [3:0] OP_SRA  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic [WIDTH-1:0] r_res, w_res_nxt;
    logic             r_carry, w_carry_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_err, w_err_nxt;
    logic [WIDTH-1:0] r_mcand, w_mcand_nxt;
    logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
    logic [WIDTH-1:0] r_acc, w_acc_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;

    logic             w_accept;
    logic             w_consume;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_acc_step;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_carry;
    logic             w_alu_ovf;
    logic             w_alu_err;

    assign in_ready  = !rst && !flush && (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_out_valid && out_ready;

    assign out_valid = r_out_valid;
    assign res       = r_res;
    assign carry     = r_carry;
    assign ovf       = r_ovf;
    assign err       = r_err;
    assign zero      = (r_res == '0);
    assign neg       = r_res[WIDTH-1];

    // Extra top bit: carry-out for ADD, borrow for SUB.
    assign w_sum      = {1'b0, operand0} + {1'b0, operand1};
    assign w_diff     = {1'b0, operand0} - {1'b0, operand1};
    assign w_shamt    = operand1[SHW-1:0];
    assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Single-cycle datapath for every op except MUL.
    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        w_alu_ovf   = 1'b0;
        w_alu_err   = 1'b0;
        case (op)
            OP_ADD: begin
                w_alu_res   = w_sum[WIDTH-1:0];
                w_alu_carry = w_sum[WIDTH];
                w_alu_ovf   = (operand0[WIDTH-1] == operand1[WIDTH-1]) &&
                              (w_sum[WIDTH-1] != operand0[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res   = w_diff[WIDTH-1:0];
                w_alu_carry = !w_diff[WIDTH];
                w_alu_ovf   = (operand0[WIDTH-1] != operand1[WIDTH-1]) &&
                              (w_diff[WIDTH-1] != operand0[WIDTH-1]);
            end
            OP_SLL:  w_alu_res = operand0 << w_shamt;
            OP_SRL:  w_alu_res = operand0 >> w_shamt;
            OP_SRA:  w_alu_res = $unsigned($signed(operand0) >>> w_shamt);
            OP_AND:  w_alu_res = operand0 & operand1;
            OP_OR:   w_alu_res = operand0 | operand1;
            OP_XOR:  w_alu_res = operand0 ^ operand1;
            OP_SLT:  w_alu_res = WIDTH'($signed(operand0) < $signed(operand1));
            OP_SLTU: w_alu_res = WIDTH'(operand0 < operand1);
            OP_MUL:  w_alu_res = '0;
            default: w_alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_res       <= '0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_res       <= w_res_nxt;
            r_carry     <= w_carry_nxt;
            r_ovf       <= w_ovf_nxt;
            r_err       <= w_err_nxt;
            r_mcand     <= w_mcand_nxt;
            r_mplier    <= w_mplier_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_out_valid_nxt = r_out_valid;
        w_res_nxt       = r_res;
        w_carry_nxt     = r_carry;
        w_ovf_nxt       = r_ovf;
        w_err_nxt       = r_err;
        w_mcand_nxt     = r_mcand;
        w_mplier_nxt    = r_mplier;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        if (flush) begin
            w_state_nxt     = S_IDLE;
            w_out_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_consume) begin
                        w_out_valid_nxt = 1'b0;
                    end
                    if (w_accept) begin
                        if (op == OP_MUL) begin
                            w_mcand_nxt  = operand0;
                            w_mplier_nxt = operand1;
                            w_acc_nxt    = '0;
                            w_cnt_nxt    = CW'(WIDTH);
                            w_state_nxt  = S_MUL;
                        end else begin
                            w_res_nxt       = w_alu_res;
                            w_carry_nxt     = w_alu_carry;
                            w_ovf_nxt       = w_alu_ovf;
                            w_err_nxt       = w_alu_err;
                            w_out_valid_nxt = 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    w_acc_nxt    = w_acc_step;
                    w_mcand_nxt  = r_mcand << 1;
                    w_mplier_nxt = r_mplier >> 1;
                    w_cnt_nxt    = r_cnt - CW'(1);
                    // The last multiplier bit and the writeback share one edge.
                    if (r_cnt == CW'(1)) begin
                        w_res_nxt       = w_acc_step;
                        w_carry_nxt     = 1'b0;
                        w_ovf_nxt       = 1'b0;
                        w_err_nxt       = 1'b0;
                        w_out_valid_nxt = 1'b1;
                        w_state_nxt     = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

endmodule
